// File: rtl/dmem_responder.sv
// dmem_responder: responder end of the core data-memory port.
// Word-organised RAM with LATENCY wait states and mem_stall back-pressure.
// Optional macro DMEM_ALIGN_CHECK_EN: flag misaligned writes on addr_err.
// Ports:
//   clk, rst (async active-low)
//   mem_en, mem_write_en[3:0], mem_addr[31:0], write_data[31:0] : request
//   read_data[31:0], resp_valid : response (resp_valid one-cycle pulse)
//   mem_stall : freeze pipeline and hold request while high
//   addr_err  : misaligned write flag with resp_valid (0 without macro)
module dmem_responder #(
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_en,
   input  logic [3:0]  mem_write_en,
   input  logic [31:0] mem_addr,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        resp_valid,
   output logic        mem_stall,
   output logic        addr_err
);

   typedef enum logic {IDLE, WAIT} state_t;

   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   state_t            state, state_nx;
   logic [3:0]        cnt, cnt_nx;
   logic [ADDR_W-1:0] idx_q;
   logic [3:0]        be_q;
   logic [31:0]       wd_q;
   logic              err_q;

   logic [31:0]       ram [2**ADDR_W];

   logic [ADDR_W-1:0] req_idx;
   logic              req_err;
   logic              accept;

   logic              acc;
   logic [ADDR_W-1:0] acc_idx;
   logic [3:0]        acc_be;
   logic [31:0]       acc_wd;
   logic              acc_err;

   logic              unused_bits;

   assign req_idx     = mem_addr[ADDR_W+1:2];
   assign accept      = (state == IDLE) && mem_en;
   assign unused_bits = ^{mem_addr[31:ADDR_W+2], mem_addr[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
   always_comb begin
      req_err = 1'b1;
      case (mem_write_en)
         4'b0000:  req_err = 1'b0;
         4'b0001,
         4'b0010,
         4'b0100,
         4'b1000:  req_err = 1'b0;
         4'b0011,
         4'b1100:  req_err = mem_addr[0];
         4'b1111:  req_err = |mem_addr[1:0];
         default:  req_err = 1'b1;
      endcase
   end
`else
   assign req_err = 1'b0;
`endif

   // With LATENCY=1 the access uses the live request in its accept
   // cycle; otherwise the copy latched at accept is used from WAIT.
   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      mem_stall = 1'b0;
      acc       = 1'b0;
      acc_idx   = idx_q;
      acc_be    = be_q;
      acc_wd    = wd_q;
      acc_err   = err_q;
      unique case (state)
         IDLE: begin
            if (mem_en) begin
               if (LATENCY == 1) begin
                  acc     = 1'b1;
                  acc_idx = req_idx;
                  acc_be  = mem_write_en;
                  acc_wd  = write_data;
                  acc_err = req_err;
               end else begin
                  state_nx  = WAIT;
                  cnt_nx    = CNT_INIT;
                  mem_stall = 1'b1;
               end
            end
         end
         WAIT: begin
            cnt_nx = cnt - 4'd1;
            if (cnt == 4'd1) begin
               acc      = 1'b1;
               state_nx = IDLE;
            end else begin
               mem_stall = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         idx_q      <= '0;
         be_q       <= 4'd0;
         wd_q       <= 32'h0;
         err_q      <= 1'b0;
         read_data  <= 32'h0;
         resp_valid <= 1'b0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         resp_valid <= acc;
         if (accept) begin
            idx_q <= req_idx;
            be_q  <= mem_write_en;
            wd_q  <= write_data;
            err_q <= req_err;
         end
         if (acc && (acc_be == 4'd0)) begin
            read_data <= ram[acc_idx];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (acc && !acc_err) begin
         for (int i = 0; i < 4; i++) begin
            if (acc_be[i]) begin
               ram[acc_idx][8*i +: 8] <= acc_wd[8*i +: 8];
            end
         end
      end
   end

`ifdef DMEM_ALIGN_CHECK_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_err <= 1'b0;
      end else begin
         addr_err <= acc && acc_err;
      end
   end
`else
   assign addr_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder.
// Two instances (LATENCY 1 and 3) against a word-array reference model.
module tb_dmem_responder;

   localparam int AW    = 6;
   localparam int DEPTH = 64;

   typedef struct {
      int          due;
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        en   [2];
   logic [3:0]  we   [2];
   logic [31:0] addr [2];
   logic [31:0] wd   [2];
   logic [31:0] rd   [2];
   logic        rv   [2];
   logic        st   [2];
   logic        ae   [2];

   logic [31:0] mdl     [2][DEPTH];
   logic [31:0] last_rd [2];
   exp_t        q0[$];
   exp_t        q1[$];
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dmem_responder #(.ADDR_W(AW), .LATENCY(1)) u_l1 (
      .clk(clk), .rst(rst),
      .mem_en(en[0]), .mem_write_en(we[0]),
      .mem_addr(addr[0]), .write_data(wd[0]),
      .read_data(rd[0]), .resp_valid(rv[0]),
      .mem_stall(st[0]), .addr_err(ae[0])
   );

   dmem_responder #(.ADDR_W(AW), .LATENCY(3)) u_l3 (
      .clk(clk), .rst(rst),
      .mem_en(en[1]), .mem_write_en(we[1]),
      .mem_addr(addr[1]), .write_data(wd[1]),
      .read_data(rd[1]), .resp_valid(rv[1]),
      .mem_stall(st[1]), .addr_err(ae[1])
   );

   function automatic int lat(int k);
      return (k == 0) ? 1 : 3;
   endfunction

   function automatic logic misal(logic [3:0] w, logic [31:0] a);
      case (w)
         4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000: return 1'b0;
         4'b0011, 4'b1100: return a[0];
         4'b1111: return (a[1:0] != 2'b00);
         default: return 1'b1;
      endcase
   endfunction

   task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s [dut%0d] @cyc %0d: got %h expected %h",
                  nm, k, cyc, act, exp);
      end
   endtask

   // Issue one request at a negedge; returns at the negedge of t0+LATENCY.
   task automatic req(int k, logic [3:0] w, logic [31:0] a, logic [31:0] d);
      exp_t e;
      int   i;
      int   L;
      i = int'((a >> 2) % DEPTH);
      L = lat(k);
      en[k]   = 1'b1;
      we[k]   = w;
      addr[k] = a;
      wd[k]   = d;
      e.due   = cyc + L;
      e.err   = 1'b0;
      if (w == 4'b0000) begin
         e.data     = mdl[k][i];
         last_rd[k] = e.data;
      end else begin
`ifdef DMEM_ALIGN_CHECK_EN
         e.err = misal(w, a);
`endif
         if (!e.err) begin
            for (int b = 0; b < 4; b++) begin
               if (w[b]) mdl[k][i][8*b +: 8] = d[8*b +: 8];
            end
         end
         e.data = last_rd[k];
      end
      if (k == 0) q0.push_back(e);
      else        q1.push_back(e);
      for (int j = 0; j < L; j++) begin
         #1;
         chk("mem_stall", k, {31'd0, st[k]}, {31'd0, (j < L - 1)});
         @(negedge clk);
      end
   endtask

   task automatic idle(int k, int n);
      en[k]   = 1'b0;
      we[k]   = 4'($urandom);
      addr[k] = $urandom;
      wd[k]   = $urandom;
      repeat (n) @(negedge clk);
   endtask

   task automatic mon(int k);
      exp_t e;
      int   n;
      n = (k == 0) ? q0.size() : q1.size();
      if (rv[k]) begin
         if (n == 0) begin
            chk("spurious resp_valid", k, 32'd1, 32'd0);
         end else begin
            e = (k == 0) ? q0.pop_front() : q1.pop_front();
            chk("resp cycle", k, cyc, e.due);
            chk("read_data", k, rd[k], e.data);
            chk("addr_err", k, {31'd0, ae[k]}, {31'd0, e.err});
         end
      end else if (n > 0) begin
         e = (k == 0) ? q0[0] : q1[0];
         if (e.due <= cyc) begin
            chk("missing resp_valid", k, 32'd0, 32'd1);
            if (k == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
         end
      end
   endtask

   always @(negedge clk) begin
      if (rst === 1'b1) begin
         mon(0);
         mon(1);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] w;
      rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         en[k] = 1'b0; we[k] = 4'h0; addr[k] = 32'h0; wd[k] = 32'h0;
         last_rd[k] = 32'h0;
      end
      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk("reset read_data", k, rd[k], 32'h0);
         chk("reset resp_valid", k, {31'd0, rv[k]}, 32'd0);
         chk("reset mem_stall", k, {31'd0, st[k]}, 32'd0);
         chk("reset addr_err", k, {31'd0, ae[k]}, 32'd0);
      end
      rst = 1'b1;
      @(negedge clk);

      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < DEPTH; i++) req(k, 4'hF, 32'(i * 4), $urandom);
         req(k, 4'hF, 32'h10, 32'hDEADBEEF);
         req(k, 4'h0, 32'h10, 32'h0);
         req(k, 4'h0, 32'h20, 32'h0);
         req(k, 4'hF, 32'h40, 32'h11223344);
         req(k, 4'b0100, 32'h40, 32'h00AA0000);
         req(k, 4'h0, 32'h40, 32'h0);
         req(k, 4'hF, 32'h1000, 32'h5);
         req(k, 4'h0, 32'h0, 32'h0);
         req(k, 4'hF, 32'h42, 32'hCAFEF00D);
         req(k, 4'h0, 32'h40, 32'h0);
         idle(k, 2);
         repeat (300) begin
            w = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            req(k, w, $urandom, $urandom);
            if ($urandom_range(0, 3) == 0) idle(k, $urandom_range(1, 3));
         end
         idle(k, 6);
      end

      // Abort a LATENCY=3 write by reset in its second cycle.
      en[1] = 1'b1; we[1] = 4'hF; addr[1] = 32'h8; wd[1] = 32'h7;
      @(negedge clk);
      rst = 1'b0;
      en[1] = 1'b0;
      #1;
      chk("abort resp_valid", 1, {31'd0, rv[1]}, 32'd0);
      chk("abort mem_stall", 1, {31'd0, st[1]}, 32'd0);
      repeat (2) @(negedge clk);
      chk("abort read_data", 1, rd[1], 32'h0);
      rst = 1'b1;
      last_rd[0] = 32'h0;
      last_rd[1] = 32'h0;
      @(negedge clk);
      req(1, 4'h0, 32'h8, 32'h0);
      idle(1, 6);

      chk("queue drain", 0, 32'(q0.size() + q1.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
